// File: rtl/bus_cycle_controller_pkg.sv
// bus_cycle_controller_pkg: shared 68030 bus definitions (cycle states, port-size codes, CPU-space FC, decode helpers)
package bus_cycle_controller_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_ACK, ST_EXT, ST_BERR} state_t;
  typedef enum logic [1:0] {PS_32 = 2'b00, PS_8 = 2'b01, PS_16 = 2'b10, PS_EXT = 2'b11} port_size_t;
  localparam logic [2:0] FC_CPU = 3'b111;
  function automatic logic region_hit(logic [7:0] addr, logic [7:0] match, logic [7:0] mask);
    return ((addr ^ match) & mask) == 8'h00;
  endfunction
  // returns {DSACK1_n, DSACK0_n} for a sized port; external ports are acked by the device
  function automatic logic [1:0] dsack_n(port_size_t ps);
    return ps == PS_32 ? 2'b00 : ps == PS_8 ? 2'b10 : ps == PS_16 ? 2'b01 : 2'b11;
  endfunction
endpackage

// File: rtl/bus_cycle_controller_if.sv
// bus_cycle_controller_if: 68030 strobes/address/FC from the CPU, chip selects and acknowledges back
//   master: drives AS_n, DS_n, FC, AH, AM, EXT_DSACK*_n; slave: drives CS_n, DSACK*_n, BERR_n, BOOT
interface bus_cycle_controller_if #(parameter int NUM_REGIONS = 4);
  logic                   AS_n;
  logic                   DS_n;
  logic [2:0]             FC;
  logic [3:0]             AH;
  logic [3:0]             AM;
  logic                   EXT_DSACK0_n;
  logic                   EXT_DSACK1_n;
  logic [NUM_REGIONS-1:0] CS_n;
  logic                   DSACK0_n;
  logic                   DSACK1_n;
  logic                   BERR_n;
  logic                   BOOT;
  modport master (
    output AS_n, DS_n, FC, AH, AM, EXT_DSACK0_n, EXT_DSACK1_n,
    input  CS_n, DSACK0_n, DSACK1_n, BERR_n, BOOT
  );
  modport slave (
    input  AS_n, DS_n, FC, AH, AM, EXT_DSACK0_n, EXT_DSACK1_n,
    output CS_n, DSACK0_n, DSACK1_n, BERR_n, BOOT
  );
endinterface

// File: rtl/bus_watchdog.sv
// bus_watchdog: counts clocks of an armed bus cycle; expired pulses on the TIMEOUT-th armed clock
//   CLK, RST_n (async active-low), arm (cycle in progress), clear (cycle ended), expired
module bus_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic CLK,
  input  logic RST_n,
  input  logic arm,
  input  logic clear,
  output logic expired
);
  logic [7:0] cnt_q, cnt_d;
  // saturating so a stuck strobe cannot wrap around into a second expiry
  assign cnt_d   = clear ? 8'd0 : (arm && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
  assign expired = arm && !clear && cnt_q == 8'(TIMEOUT - 1);
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/bus_cycle_controller.sv
// bus_cycle_controller: 68030 chip-select decode, wait-state DSACK generation, bus-error watchdog and boot overlay
//   CLK, RST_n (async active-low); bus (slave modport): strobes/FC/address in, CS_n/DSACK*_n/BERR_n/BOOT out
module bus_cycle_controller
  import bus_cycle_controller_pkg::*;
#(
  parameter int                       NUM_REGIONS  = 4,
  parameter logic [8*NUM_REGIONS-1:0] REGION_MATCH = '0,
  parameter logic [8*NUM_REGIONS-1:0] REGION_MASK  = '1,
  parameter logic [4*NUM_REGIONS-1:0] REGION_WAIT  = '0,
  parameter logic [2*NUM_REGIONS-1:0] REGION_WIDTH = '0,
  parameter int                       BOOT_CYCLES  = 8,
  parameter int                       BERR_TIMEOUT = 64
) (
  input logic                  CLK,
  input logic                  RST_n,
  bus_cycle_controller_if.slave bus
);
  state_t                 state_q, state_d;
  logic [NUM_REGIONS-1:0] cs_n_q, cs_n_d, sel_cs_n;
  logic [1:0]             ds_n_q, ds_n_d;
  logic                   berr_n_q, berr_n_d;
  logic [3:0]             wait_q, wait_d, sel_wait;
  port_size_t             ps_q, ps_d, sel_ps;
  logic                   hit_q, hit_d, sel_hit;
  logic                   boot_q, boot_d;
  logic [15:0]            boot_cnt_q, boot_cnt_d;
  logic                   cycle_lo, expired;
  logic [7:0]             addr;
  assign addr     = {bus.AH, bus.AM};
  assign cycle_lo = !bus.AS_n && bus.FC != FC_CPU;
  bus_watchdog #(.TIMEOUT(BERR_TIMEOUT)) u_wd (
    .CLK     (CLK),
    .RST_n   (RST_n),
    .arm     (cycle_lo),
    .clear   (bus.AS_n),
    .expired (expired)
  );
  // descending scan so the lowest-index match is the one left standing; boot overlay forces region 0
  always_comb begin
    sel_hit  = 1'b0;
    sel_cs_n = '1;
    sel_wait = '0;
    sel_ps   = PS_32;
    for (int i = NUM_REGIONS - 1; i >= 0; i--)
      if (!boot_q ? i == 0 : region_hit(addr, REGION_MATCH[8*i +: 8], REGION_MASK[8*i +: 8])) begin
        sel_hit  = 1'b1;
        sel_cs_n = ~(NUM_REGIONS'(1) << i);
        sel_wait = REGION_WAIT[4*i +: 4];
        sel_ps   = port_size_t'(REGION_WIDTH[2*i +: 2]);
      end
  end
  always_comb begin
    state_d    = state_q;
    cs_n_d     = cs_n_q;
    ds_n_d     = ds_n_q;
    berr_n_d   = berr_n_q;
    wait_d     = wait_q;
    ps_d       = ps_q;
    hit_d      = hit_q;
    boot_d     = boot_q;
    boot_cnt_d = boot_cnt_q;
    if (state_q == ST_IDLE) begin
      if (cycle_lo) begin
        cs_n_d  = sel_cs_n;
        wait_d  = sel_wait;
        ps_d    = sel_ps;
        hit_d   = sel_hit;
        state_d = sel_hit && sel_ps == PS_EXT ? ST_EXT : ST_WAIT;
      end
    end else if (bus.AS_n) begin
      state_d  = ST_IDLE;
      cs_n_d   = '1;
      ds_n_d   = 2'b11;
      berr_n_d = 1'b1;
      if (!boot_q) begin
        boot_cnt_d = boot_cnt_q + 16'd1;
        boot_d     = boot_cnt_q == 16'(BOOT_CYCLES - 1);
      end
    end else begin
      // an unmatched cycle (hit_q low) idles in WAIT until the watchdog or AS_n ends it
      if (state_q == ST_WAIT && hit_q) begin
        if (wait_q == 4'd0) begin
          ds_n_d  = dsack_n(ps_q);
          state_d = ST_ACK;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      if (state_q == ST_EXT) ds_n_d = {bus.EXT_DSACK1_n, bus.EXT_DSACK0_n};
      // an acknowledge on the expiry edge, or one already given, suppresses the bus error
      if ((state_q == ST_WAIT || state_q == ST_EXT) && expired && &ds_n_d && &ds_n_q) begin
        berr_n_d = 1'b0;
        state_d  = ST_BERR;
      end
    end
  end
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q    <= ST_IDLE;
      cs_n_q     <= '1;
      ds_n_q     <= 2'b11;
      berr_n_q   <= 1'b1;
      wait_q     <= '0;
      ps_q       <= PS_32;
      hit_q      <= 1'b0;
      boot_q     <= 1'b0;
      boot_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cs_n_q     <= cs_n_d;
      ds_n_q     <= ds_n_d;
      berr_n_q   <= berr_n_d;
      wait_q     <= wait_d;
      ps_q       <= ps_d;
      hit_q      <= hit_d;
      boot_q     <= boot_d;
      boot_cnt_q <= boot_cnt_d;
    end
  end
  assign bus.CS_n     = cs_n_q;
  assign bus.DSACK0_n = ds_n_q[0];
  assign bus.DSACK1_n = ds_n_q[1];
  assign bus.BERR_n   = berr_n_q;
  assign bus.BOOT     = boot_q;
endmodule

// File: tb/tb_bus_cycle_controller.sv
// tb_bus_cycle_controller: randomized bus cycles checked against a cycle-level reference model
module tb_bus_cycle_controller;
  localparam int NR = 5;
  localparam int TO = 64;
  localparam int BC = 8;
  // regions: r0 Fx w1 32b, r1 00 exact w3 32b, r2 2x w0 8b, r3 2x/3x w2 16b (r2 wins on 2x), r4 5x ext
  localparam logic [8*NR-1:0] MATCH  = {8'h50, 8'h20, 8'h20, 8'h00, 8'hF0};
  localparam logic [8*NR-1:0] MASK   = {8'hF0, 8'hE0, 8'hF0, 8'hFF, 8'hF0};
  localparam logic [4*NR-1:0] WAITS  = {4'd0, 4'd2, 4'd0, 4'd3, 4'd1};
  localparam logic [2*NR-1:0] WIDTHS = {2'b11, 2'b10, 2'b01, 2'b00, 2'b00};

  logic CLK = 1'b0;
  logic RST_n = 1'b0;
  always #5 CLK = ~CLK;

  bus_cycle_controller_if #(.NUM_REGIONS(NR)) bus ();

  bus_cycle_controller #(
    .NUM_REGIONS (NR),
    .REGION_MATCH(MATCH),
    .REGION_MASK (MASK),
    .REGION_WAIT (WAITS),
    .REGION_WIDTH(WIDTHS),
    .BOOT_CYCLES (BC),
    .BERR_TIMEOUT(TO)
  ) dut (
    .CLK  (CLK),
    .RST_n(RST_n),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model: a cycle is "edges since AS_n was first sampled low" plus the decoded region
  bit   m_act, m_berr, m_acked;
  int   m_k, m_r, m_boots;
  logic [1:0] m_ds;
  int   first_ds, first_berr;

  function automatic int find_region(input logic [7:0] a);
    for (int i = 0; i < NR; i++)
      if (((a ^ MATCH[8*i +: 8]) & MASK[8*i +: 8]) == 8'h00) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_act = 0; m_berr = 0; m_acked = 0; m_k = 0; m_r = -1; m_boots = 0; m_ds = 2'b11;
  endtask

  task automatic model_edge();
    int wd, w;
    if (!m_act) begin
      if (!bus.AS_n && bus.FC != 3'b111) begin
        m_act = 1; m_k = 0; m_berr = 0; m_acked = 0; m_ds = 2'b11;
        m_r = (m_boots < BC) ? 0 : find_region({bus.AH, bus.AM});
      end
    end else if (bus.AS_n) begin
      m_act = 0;
      m_boots++;
    end else begin
      m_k++;
    end
    if (m_act && !m_berr) begin
      if (m_r < 0) m_ds = 2'b11;
      else begin
        wd = int'(WIDTHS[2*m_r +: 2]);
        w  = int'(WAITS[4*m_r +: 4]);
        if (wd == 3) m_ds = (m_k >= 1) ? {bus.EXT_DSACK1_n, bus.EXT_DSACK0_n} : 2'b11;
        else if (m_k >= w + 1) m_ds = {!(wd == 0 || wd == 2), !(wd == 0 || wd == 1)};
        else m_ds = 2'b11;
      end
      if (m_ds != 2'b11) m_acked = 1;
      if (m_k == TO - 1 && !m_acked) m_berr = 1;
    end
  endtask

  task automatic step();
    logic [NR-1:0] e_cs;
    @(posedge CLK);
    model_edge();
    #1;
    e_cs = '1;
    if (m_act && m_r >= 0) e_cs[m_r] = 1'b0;
    check("cs_n", 32'(bus.CS_n), 32'(e_cs));
    check("dsack0_n", 32'(bus.DSACK0_n), 32'(m_act ? m_ds[0] : 1'b1));
    check("dsack1_n", 32'(bus.DSACK1_n), 32'(m_act ? m_ds[1] : 1'b1));
    check("berr_n", 32'(bus.BERR_n), 32'(!(m_act && m_berr)));
    check("boot", 32'(bus.BOOT), 32'(m_boots >= BC));
  endtask

  task automatic idle(input int n);
    bus.AS_n = 1'b1; bus.DS_n = 1'b1;
    bus.EXT_DSACK0_n = 1'b1; bus.EXT_DSACK1_n = 1'b1;
    for (int j = 0; j < n; j++) step();
  endtask

  // AS_n low for len sampling edges then one edge sampling it high; EXT strobes go low after edge ext_at
  task automatic run_cycle(input logic [3:0] ah, input logic [3:0] am, input logic [2:0] fc,
                           input int len, input int ext_at, input logic [1:0] ext_sel);
    logic lowx;
    first_ds = -1;
    first_berr = -1;
    for (int j = 0; j <= len; j++) begin
      bus.AS_n = (j == len);
      bus.DS_n = bus.AS_n;
      bus.FC = fc; bus.AH = ah; bus.AM = am;
      lowx = ext_at >= 0 && j > ext_at && j < len;
      bus.EXT_DSACK0_n = !(lowx && ext_sel[0]);
      bus.EXT_DSACK1_n = !(lowx && ext_sel[1]);
      step();
      if (first_ds < 0 && j < len && (!bus.DSACK0_n || !bus.DSACK1_n)) first_ds = j;
      if (first_berr < 0 && j < len && !bus.BERR_n) first_berr = j;
    end
    bus.EXT_DSACK0_n = 1'b1;
    bus.EXT_DSACK1_n = 1'b1;
  endtask

  initial begin
    model_reset();
    bus.AS_n = 1'b1; bus.DS_n = 1'b1; bus.FC = 3'd1; bus.AH = 4'h0; bus.AM = 4'h0;
    bus.EXT_DSACK0_n = 1'b1; bus.EXT_DSACK1_n = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_cs_n", 32'(bus.CS_n), 32'(5'h1F));
    check("rst_dsack", 32'({bus.DSACK1_n, bus.DSACK0_n}), 32'h3);
    check("rst_berr_n", 32'(bus.BERR_n), 32'h1);
    check("rst_boot", 32'(bus.BOOT), 32'h0);
    @(negedge CLK);
    RST_n = 1'b1;
    idle(2);
    // boot overlay: eight cycles all land on region 0, then 0x00 decodes to region 1
    for (int c = 0; c < BC; c++) begin
      run_cycle(4'h0, 4'h0, 3'd1, 4, -1, 2'b00);
      idle(1);
    end
    check("boot_up", 32'(bus.BOOT), 32'h1);
    run_cycle(4'h0, 4'h0, 3'd5, 6, -1, 2'b00);
    check("wait3_first_ds", 32'(first_ds), 32'd4);
    idle(1);
    run_cycle(4'h2, 4'h7, 3'd1, 4, -1, 2'b00);
    check("w8_first_ds", 32'(first_ds), 32'd1);
    run_cycle(4'h3, 4'h1, 3'd2, 5, -1, 2'b00);
    check("w16_first_ds", 32'(first_ds), 32'd3);
    idle(1);
    run_cycle(4'h4, 4'h0, 3'd1, 70, -1, 2'b00);
    check("to_first_berr", 32'(first_berr), 32'd63);
    check("to_no_ds", 32'(first_ds), 32'hFFFF_FFFF);
    idle(1);
    run_cycle(4'h5, 4'h3, 3'd1, 9, 4, 2'b10);
    check("ext_first_ds", 32'(first_ds), 32'd5);
    run_cycle(4'h5, 4'h0, 3'd1, 68, -1, 2'b00);
    check("ext_to_berr", 32'(first_berr), 32'd63);
    idle(2);
    run_cycle(4'h0, 4'h0, 3'd1, 2, -1, 2'b00);
    check("abort_no_ds", 32'(first_ds), 32'hFFFF_FFFF);
    run_cycle(4'h0, 4'h0, 3'd7, 5, 0, 2'b11);
    check("cpu_no_ds", 32'(first_ds), 32'hFFFF_FFFF);
    for (int c = 0; c < 150; c++) begin
      logic [3:0] ah, am;
      logic [2:0] fc;
      ah = 4'($urandom_range(0, 15));
      am = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      fc = ($urandom_range(0, 9) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
      run_cycle(ah, am, fc, $urandom_range(1, 12), $urandom_range(0, 7) - 1, 2'($urandom_range(1, 3)));
      idle($urandom_range(0, 2));
    end
    // reset mid-cycle clears outputs immediately and restarts the boot overlay
    bus.AS_n = 1'b0; bus.DS_n = 1'b0; bus.FC = 3'd1; bus.AH = 4'h0; bus.AM = 4'h0;
    step();
    step();
    #2;
    RST_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_cs_n", 32'(bus.CS_n), 32'(5'h1F));
    check("mid_rst_dsack", 32'({bus.DSACK1_n, bus.DSACK0_n}), 32'h3);
    check("mid_rst_berr_n", 32'(bus.BERR_n), 32'h1);
    check("mid_rst_boot", 32'(bus.BOOT), 32'h0);
    bus.AS_n = 1'b1; bus.DS_n = 1'b1;
    @(negedge CLK);
    RST_n = 1'b1;
    idle(1);
    for (int c = 0; c < BC + 3; c++) begin
      run_cycle(4'($urandom_range(0, 15)), 4'h0, 3'd1, $urandom_range(1, 6), -1, 2'b00);
      idle($urandom_range(0, 1));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bus_cycle_controller.md
BUS_CYCLE_CONTROLLER -- requirements
Module: bus_cycle_controller

Interface
REQ-001 SHALL have parameter NUM_REGIONS, default 4: number of decoded chip-select regions, 1..8.
REQ-002 SHALL have parameter REGION_MATCH [8*NUM_REGIONS-1:0], default 0: per-region compare value on {AH,AM}.
REQ-003 SHALL have parameter REGION_MASK [8*NUM_REGIONS-1:0], default all ones: per-region compare mask; a 1 bit is compared.
REQ-004 SHALL have parameter REGION_WAIT [4*NUM_REGIONS-1:0], default 0: per-region wait states, 0..15.
REQ-005 SHALL have parameter REGION_WIDTH [2*NUM_REGIONS-1:0], default 0: per-region port size; 00=32-bit, 01=8-bit, 10=16-bit, 11=external.
REQ-006 SHALL have parameter BOOT_CYCLES, default 8: number of bus cycles during which region 0 overlays all memory space.
REQ-007 SHALL have parameter BERR_TIMEOUT, default 64: clocks of AS_n assertion before bus error, 2..255.
REQ-008 CLK  in  1  system clock; one clock domain.
REQ-009 RST_n  in  1  reset, asynchronous, active-low.
REQ-010 AS_n, DS_n  in  1 each  68030 address/data strobes, active-low.
REQ-011 FC  in  3  function code; 3'b111 = CPU space.
REQ-012 AH  in  4  address [31:28]; AM  in  4  address [19:16].
REQ-013 EXT_DSACK0_n, EXT_DSACK1_n  in  1 each  device-driven acknowledge for external-width regions.
REQ-014 CS_n  out  NUM_REGIONS  registered chip selects, active-low, one-hot or all high.
REQ-015 DSACK0_n, DSACK1_n  out  1 each  registered port-size acknowledge, active-low.
REQ-016 BERR_n  out  1  registered bus error, active-low.
REQ-017 BOOT  out  1  high once boot overlay has ended.

Function
REQ-018 SHALL implement the states IDLE, WAIT, ACK, EXT and BERR, all sampled on rising CLK.
REQ-019 IDLE: with AS_n low and FC != 111, SHALL latch the lowest-index matching region, assert its CS_n at the same edge, load the wait counter from REGION_WAIT, and enter WAIT, or EXT if the width is 11.
REQ-020 IDLE with no region matching SHALL enter WAIT with no CS_n asserted and no acknowledge pending, so only the timeout can terminate the cycle.
REQ-021 WAIT SHALL decrement the counter each clock; at the edge it reads 0, it SHALL assert DSACK per width (00: both low; 01: DSACK0 only; 10: DSACK1 only) and enter ACK.
REQ-022 For a region with WAIT=W, DSACK SHALL go low W+1 edges after the edge that sampled AS_n low.
REQ-023 EXT SHALL copy EXT_DSACK0_n/EXT_DSACK1_n to DSACK0_n/DSACK1_n one clock later.
REQ-024 In any non-IDLE state, AS_n sampled high SHALL negate CS_n, DSACK and BERR_n at that edge and return to IDLE; this covers both normal end and aborted cycles.
REQ-025 The watchdog SHALL count clocks while AS_n is low in a non-CPU-space cycle; at BERR_TIMEOUT, unless DSACK is already asserted, it SHALL assert BERR_n, hold it until AS_n goes high, and enter BERR.
REQ-026 Timeout and DSACK on the same edge: DSACK SHALL win and BERR_n SHALL stay high.
REQ-027 CPU-space cycles SHALL get no CS_n, no DSACK, no BERR_n; the block stays in IDLE.
REQ-028 While BOOT=0, every non-CPU-space cycle SHALL select region 0 regardless of address.
REQ-029 The boot counter SHALL count AS_n low-to-high transitions of non-CPU-space cycles; BOOT SHALL rise at the edge that ends cycle BOOT_CYCLES and SHALL stay high until reset.

Reset
REQ-030 RST_n low SHALL immediately force CS_n all high, DSACK0_n=DSACK1_n=1, BERR_n=1, BOOT=0, state IDLE, and clear all counters, including during an active cycle.
REQ-031 After RST_n rises, the first AS_n sample SHALL be taken at the next rising CLK.

Structure
REQ-032 Width encodings, state encodings and the CPU-space FC constant SHALL live in the shared bus-definitions header used by the board's controllers.
REQ-033 Timeout counting SHALL be one sub-module, bus_watchdog (inputs: CLK, RST_n, arm, clear; output: expired); all else stays in bus_cycle_controller.

Verification
REQ-034 Boot: after reset, 8 reads at 0x00000000 -> CS_n[0] low each cycle; on the 9th cycle BOOT=1, and 0x00000000 selects the region whose REGION_MATCH is 0x00.
REQ-035 Wait states: region with WAIT=3, width 00, AS_n sampled low at edge N -> CS_n low at N, DSACK0_n=DSACK1_n=0 at N+4, both high at the edge that samples AS_n high.
REQ-036 Width: 8-bit region -> only DSACK0_n low; 16-bit region -> only DSACK1_n low.
REQ-037 Timeout: unmapped address 0x40000000, AS_n held low -> BERR_n low exactly at clock 64, DSACK never asserted; BERR_n released when AS_n goes high.
REQ-038 External: EXT_DSACK1_n pulled low at clock 5 -> DSACK1_n low at clock 6; if it is never pulled, BERR_n goes low at clock 64.
REQ-039 Abort/reset: AS_n negated at WAIT count 2 -> return to IDLE with no DSACK; RST_n pulsed mid-cycle -> all outputs high at once, BOOT=0.
